fpdiv_req_rsp_ctrl: RTL

//  Single-outstanding issue/collect controller between a pipeline request port and fpdiv_scalar_r64.

---
 rtl/fpdiv_pkg.sv | 20 ++
 rtl/fpdiv_req_rsp_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fpdiv_pkg.sv
// Shared encodings and controller state type for the scalar divider block.
package fpdiv_pkg;

   localparam logic [1:0] FMT_F16 = 2'b00;
   localparam logic [1:0] FMT_F32 = 2'b01;
   localparam logic [1:0] FMT_F64 = 2'b10;
   localparam logic [1:0] FMT_ILL = 2'b11;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   // fflags layout is {NV,DZ,OF,UF,NX}
   localparam int FFLAG_NV = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fpdiv_ctrl_state_t;

endpackage

// File: rtl/fpdiv_req_rsp_ctrl.sv
// Single-outstanding issue/collect controller in front of fpdiv_scalar_r64:
// latches one request, drives the divider start/finish handshakes, returns a tagged response.
module fpdiv_req_rsp_ctrl
   import fpdiv_pkg::*;
#(
   parameter int          TAG_W   = 4,
   parameter int unsigned TIMEOUT = 255,
   parameter int          CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [TAG_W-1:0] req_tag_i,
   input  logic [1:0]       req_fmt_i,
   input  logic [63:0]      req_opa_i,
   input  logic [63:0]      req_opb_i,
   input  logic [2:0]       req_rm_i,
   output logic             div_start_valid_o,
   input  logic             div_start_ready_i,
   output logic             div_flush_o,
   output logic [1:0]       div_fmt_o,
   output logic [63:0]      div_opa_o,
   output logic [63:0]      div_opb_o,
   output logic [2:0]       div_rm_o,
   input  logic             div_finish_valid_i,
   output logic             div_finish_ready_o,
   input  logic [63:0]      div_res_i,
   input  logic [4:0]       div_fflags_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic [63:0]      rsp_res_o,
   output logic [4:0]       rsp_fflags_o,
   output logic             err_timeout_o,
   output logic [CNT_W-1:0] done_cnt_o
);

   fpdiv_ctrl_state_t state_q, state_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [1:0]        fmt_q, fmt_d;
   logic [63:0]       opa_q, opa_d;
   logic [63:0]       opb_q, opb_d;
   logic [2:0]        rm_q, rm_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [63:0]       rsp_res_q, rsp_res_d;
   logic [4:0]        rsp_fflags_q, rsp_fflags_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
   logic [31:0]       wait_cnt_q, wait_cnt_d;

   logic req_hs, start_hs, finish_hs, rsp_hs;

   // Flush masks every handshake so it wins over any transfer in the same cycle.
   assign div_flush_o        = flush_i;
   assign req_ready_o        = (state_q == IDLE)  && !flush_i;
   assign div_start_valid_o  = (state_q == ISSUE) && !flush_i;
   assign div_finish_ready_o = (state_q == WAIT)  && !flush_i;
   assign rsp_valid_o        = (state_q == RESP)  && !flush_i;

   assign req_hs    = req_valid_i        && req_ready_o;
   assign start_hs  = div_start_valid_o  && div_start_ready_i;
   assign finish_hs = div_finish_valid_i && div_finish_ready_o;
   assign rsp_hs    = rsp_valid_o        && rsp_ready_i;

   assign div_fmt_o     = fmt_q;
   assign div_opa_o     = opa_q;
   assign div_opb_o     = opb_q;
   assign div_rm_o      = rm_q;
   assign rsp_tag_o     = rsp_tag_q;
   assign rsp_res_o     = rsp_res_q;
   assign rsp_fflags_o  = rsp_fflags_q;
   assign err_timeout_o = err_q;
   assign done_cnt_o    = done_cnt_q;

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      fmt_d        = fmt_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      rm_d         = rm_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_res_d    = rsp_res_q;
      rsp_fflags_d = rsp_fflags_q;
      err_d        = err_q;
      done_cnt_d   = done_cnt_q;
      wait_cnt_d   = wait_cnt_q;

      case (state_q)
         IDLE: begin
            if (req_hs) begin
               tag_d = req_tag_i;
               fmt_d = req_fmt_i;
               opa_d = req_opa_i;
               opb_d = req_opb_i;
               rm_d  = req_rm_i;
               if (req_fmt_i == FMT_ILL) begin
                  // Illegal format is answered locally; the divider is never started.
                  rsp_tag_d    = req_tag_i;
                  rsp_res_d    = '0;
                  rsp_fflags_d = 5'b00001 << FFLAG_NV;
                  state_d      = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (start_hs) begin
               wait_cnt_d = '0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
            if ((TIMEOUT != 0) && !flush_i && (wait_cnt_d >= TIMEOUT)) begin
               err_d = 1'b1;
            end
            if (finish_hs) begin
               rsp_tag_d    = tag_q;
               rsp_res_d    = div_res_i;
               rsp_fflags_d = div_fflags_i;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_hs) begin
               done_cnt_d = done_cnt_q + CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tag_q        <= '0;
         fmt_q        <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         rm_q         <= '0;
         rsp_tag_q    <= '0;
         rsp_res_q    <= '0;
         rsp_fflags_q <= '0;
         err_q        <= 1'b0;
         done_cnt_q   <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         fmt_q        <= fmt_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         rm_q         <= rm_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_res_q    <= rsp_res_d;
         rsp_fflags_q <= rsp_fflags_d;
         err_q        <= err_d;
         done_cnt_q   <= done_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

endmodule
